// File: rtl/seg7_pkg.sv
// Shared types and constants for the 74HC595 seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEG_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_HOLD,
    ST_BLANK
  } scan_state_e;

  // Active-high {dp,g,f,e,d,c,b,a}; dp is always 0 here.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hc595_shifter.sv
// Serialises one 16-bit word MSB first into the 595 pair, then pulses the latch.
module seg7_hc595_shifter
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              sclk,
  output logic              rclk,
  output logic              dio,
  output logic              shift_end_c,
  output logic              done_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              shifting;
  logic              latching;
  logic              div_end_c;

  assign div_end_c   = (div_cnt == DIV_LAST);
  assign shift_end_c = shifting && sclk && div_end_c && (bit_cnt == BIT_LAST);
  assign done_c      = latching && div_end_c;

  // dio only moves together with a falling sclk, so it is stable across every rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      shifting <= 1'b0;
      latching <= 1'b0;
      sclk     <= 1'b0;
      rclk     <= 1'b0;
      dio      <= 1'b0;
    end else if (start) begin
      sreg     <= word;
      dio      <= word[WORD_W-1];
      sclk     <= 1'b0;
      rclk     <= 1'b0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      shifting <= 1'b1;
      latching <= 1'b0;
    end else if (shifting) begin
      if (div_end_c) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (bit_cnt == BIT_LAST) begin
          sclk     <= 1'b0;
          dio      <= 1'b0;
          rclk     <= 1'b1;
          shifting <= 1'b0;
          latching <= 1'b1;
        end else begin
          sclk    <= 1'b0;
          sreg    <= {sreg[WORD_W-2:0], 1'b0};
          dio     <= sreg[WORD_W-2];
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else if (latching) begin
      if (div_end_c) begin
        rclk     <= 1'b0;
        latching <= 1'b0;
        div_cnt  <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_hc595_scan.sv
// Multiplexed 7-segment scanner for a 74HC595 pair: snapshots inputs per frame,
// builds one segment+select word per digit and blanks the display on disable.
module seg7_hc595_scan
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned SCAN_HOLD      = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [8*N_DIGITS-1:0] raw_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic                  seg7_sclk,
  output logic                  seg7_rclk,
  output logic                  seg7_dio,
  output logic [2:0]            digit_idx,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int unsigned HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(N_DIGITS - 1);
  localparam logic [WORD_W-1:0] BLANK_WORD = {(SEG_ACTIVE_LOW ? 8'hFF : 8'h00),
                                              (DIG_ACTIVE_LOW ? 8'hFF : 8'h00)};

  scan_state_e state;
  logic [HOLD_W-1:0] hold_cnt;

  logic                  sh_mode;
  logic [4*N_DIGITS-1:0] sh_hex;
  logic [8*N_DIGITS-1:0] sh_raw;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blank;

  logic                  src_mode_c;
  logic [4*N_DIGITS-1:0] src_hex_c;
  logic [8*N_DIGITS-1:0] src_raw_c;
  logic [N_DIGITS-1:0]   src_dp_c;
  logic [N_DIGITS-1:0]   src_blank_c;
  logic [SEG_W-1:0]      seg_c;
  logic [SEG_W-1:0]      sel_c;
  logic [WORD_W-1:0]     digit_word_c;
  logic [WORD_W-1:0]     word_c;
  logic                  hold_last_c;
  logic                  start_c;
  logic                  shift_end_c;
  logic                  done_c;

  // Digit 0 is built from the live inputs, which are the ones being snapshotted this cycle
  always_comb begin
    src_mode_c  = sh_mode;
    src_hex_c   = sh_hex;
    src_raw_c   = sh_raw;
    src_dp_c    = sh_dp;
    src_blank_c = sh_blank;
    if (digit_idx == 3'd0) begin
      src_mode_c  = mode;
      src_hex_c   = hex_in;
      src_raw_c   = raw_in;
      src_dp_c    = dp_in;
      src_blank_c = blank_in;
    end
  end

  always_comb begin
    seg_c = '0;
    sel_c = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_idx == 3'(k)) begin
        seg_c    = src_mode_c ? src_raw_c[8*k +: 8] : hex_to_seg(src_hex_c[4*k +: 4]);
        seg_c[7] = seg_c[7] | src_dp_c[k];
        if (src_blank_c[k]) seg_c = '0;
        sel_c[k] = 1'b1;
      end
    end
    digit_word_c = {(SEG_ACTIVE_LOW ? ~seg_c : seg_c), (DIG_ACTIVE_LOW ? ~sel_c : sel_c)};
  end

  assign hold_last_c = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);
  // The blank word starts in the last HOLD cycle so BLANK itself is exactly shift+latch long
  assign start_c     = (state == ST_LOAD) || (hold_last_c && !en);
  assign word_c      = (state == ST_LOAD) ? digit_word_c : BLANK_WORD;

  seg7_hc595_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .start       (start_c),
    .word        (word_c),
    .sclk        (seg7_sclk),
    .rclk        (seg7_rclk),
    .dio         (seg7_dio),
    .shift_end_c (shift_end_c),
    .done_c      (done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      sh_mode    <= 1'b0;
      sh_hex     <= '0;
      sh_raw     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state     <= ST_LOAD;
            digit_idx <= 3'd0;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (digit_idx == 3'd0) begin
            sh_mode  <= mode;
            sh_hex   <= hex_in;
            sh_raw   <= raw_in;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
          end
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (shift_end_c) state <= ST_LATCH;
        end
        ST_LATCH: begin
          if (done_c) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            if (!en) begin
              state <= ST_BLANK;
            end else begin
              state <= ST_LOAD;
              if (digit_idx == IDX_LAST) begin
                digit_idx  <= 3'd0;
                frame_done <= 1'b1;
              end else begin
                digit_idx <= digit_idx + 3'd1;
              end
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (done_c) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_hc595_scan.sv
// Bench for seg7_hc595_scan: cycle model of the scan timeline plus directed word checks.
module tb_seg7_hc595_scan;

  localparam int CD  = 2;
  localparam int SH  = 4;
  localparam int N   = 8;
  localparam int PER = 1 + 33*CD + SH;
  localparam int BLK = 33*CD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en = 1'b0, mode = 1'b0;
  logic [31:0] hex = '0;
  logic [63:0] raw = '0;
  logic [7:0]  dp = '0, blank = '0;
  logic        sclk_a, rclk_a, dio_a, fd_a, busy_a;
  logic [2:0]  idx_a;

  logic        en_b = 1'b0;
  logic [15:0] hex_b = '0;
  logic        sclk_b, rclk_b, dio_b, fd_b, busy_b;
  logic [2:0]  idx_b;

  seg7_hc595_scan #(.N_DIGITS(N), .CLK_DIV(CD), .SCAN_HOLD(SH),
                    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hex_in(hex), .raw_in(raw),
    .dp_in(dp), .blank_in(blank), .seg7_sclk(sclk_a), .seg7_rclk(rclk_a),
    .seg7_dio(dio_a), .digit_idx(idx_a), .frame_done(fd_a), .busy(busy_a));

  seg7_hc595_scan #(.N_DIGITS(4), .CLK_DIV(CD), .SCAN_HOLD(SH),
                    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(1'b0), .hex_in(hex_b), .raw_in(32'h0),
    .dp_in(4'h0), .blank_in(4'h0), .seg7_sclk(sclk_b), .seg7_rclk(rclk_b),
    .seg7_dio(dio_b), .digit_idx(idx_b), .frame_done(fd_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
      4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
      4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
      4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h71;
    endcase
  endfunction

  // Word for digit k of the active-low instance
  function automatic logic [15:0] tb_build(input logic md, input logic [31:0] hx,
                                           input logic [63:0] rw, input logic [7:0] dpv,
                                           input logic [7:0] bl, input int k);
    logic [7:0] seg;
    logic [7:0] sel;
    seg = md ? rw[8*k +: 8] : seg_of(hx[4*k +: 4]);
    if (dpv[k]) seg = seg | 8'h80;
    if (bl[k]) seg = 8'h00;
    sel = 8'd1 << k;
    return {~seg, ~sel};
  endfunction

  // Model: phase 0 idle, 1 scanning (t counts within a digit, t=0 is the load cycle), 2 blanking
  int          m_ph = 0;
  int          m_t = 0;
  logic [2:0]  m_idx = 3'd0;
  logic        m_fd = 1'b0;
  logic [15:0] m_word = '0;
  logic        s_mode = 1'b0;
  logic [31:0] s_hex = '0;
  logic [63:0] s_raw = '0;
  logic [7:0]  s_dp = '0, s_bl = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_t <= 0; m_idx <= 3'd0; m_fd <= 1'b0; m_word <= '0;
      s_mode <= 1'b0; s_hex <= '0; s_raw <= '0; s_dp <= '0; s_bl <= '0;
    end else begin
      m_fd <= 1'b0;
      if (m_ph == 0) begin
        if (en) begin m_ph <= 1; m_t <= 0; m_idx <= 3'd0; end
      end else if (m_ph == 1) begin
        if (m_t == 0) begin
          if (m_idx == 3'd0) begin
            s_mode <= mode; s_hex <= hex; s_raw <= raw; s_dp <= dp; s_bl <= blank;
            m_word <= tb_build(mode, hex, raw, dp, blank, 0);
          end else begin
            m_word <= tb_build(s_mode, s_hex, s_raw, s_dp, s_bl, int'(m_idx));
          end
        end
        if (m_t == PER-1) begin
          m_t <= 0;
          if (!en) m_ph <= 2;
          else if (int'(m_idx) == N-1) begin m_idx <= 3'd0; m_fd <= 1'b1; end
          else m_idx <= m_idx + 3'd1;
        end else begin
          m_t <= m_t + 1;
        end
      end else begin
        if (m_t == BLK-1) begin m_ph <= 0; m_t <= 0; end
        else m_t <= m_t + 1;
      end
    end
  end

  // {sclk, rclk, dio, idx[2:0], frame_done, busy} the model requires this cycle
  function automatic logic [7:0] exp_out();
    int u;
    logic s, r, d;
    logic [15:0] w;
    s = 1'b0; r = 1'b0; d = 1'b0; u = -1; w = m_word;
    if (m_ph == 1) u = m_t - 1;
    else if (m_ph == 2) begin u = m_t; w = 16'hFFFF; end
    if (u >= 0 && u < 32*CD) begin
      s = ((u % (2*CD)) >= CD);
      d = w[15 - u/(2*CD)];
    end else if (u >= 32*CD && u < 33*CD) begin
      r = 1'b1;
    end
    return {s, r, d, m_idx, m_fd, (m_ph != 0)};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({sclk_a, rclk_a, dio_a, idx_a, fd_a, busy_a} !== exp_out()) begin
        errors++;
        $display("FAIL cycle_outputs at %0t: got %b required %b", $time,
                 {sclk_a, rclk_a, dio_a, idx_a, fd_a, busy_a}, exp_out());
      end
    end
  end

  // Word monitors: collect bits on sclk rises, record {idx, word} on each rclk rise
  logic [18:0] a_q[$];
  logic [18:0] b_q[$];
  logic [15:0] a_sh = '0, b_sh = '0;
  logic a_ps = 1'b0, a_pr = 1'b0, b_ps = 1'b0, b_pr = 1'b0;

  always @(negedge clk) begin
    if (sclk_a && !a_ps) a_sh <= {a_sh[14:0], dio_a};
    if (rclk_a && !a_pr) a_q.push_back({idx_a, a_sh});
    a_ps <= sclk_a; a_pr <= rclk_a;
    if (sclk_b && !b_ps) b_sh <= {b_sh[14:0], dio_b};
    if (rclk_b && !b_pr) b_q.push_back({idx_b, b_sh});
    b_ps <= sclk_b; b_pr <= rclk_b;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic check_word(input bit b, input string nm, input logic [2:0] ei,
                            input logic [15:0] ew);
    int n = 0;
    logic [18:0] e;
    while ((b ? b_q.size() : a_q.size()) == 0 && n < 2000) begin @(negedge clk); n++; end
    if ((b ? b_q.size() : a_q.size()) == 0) begin
      checks++; errors++;
      $display("FAIL %s: no word latched within 2000 cycles, required %h", nm, ew);
    end else begin
      e = b ? b_q.pop_front() : a_q.pop_front();
      chk(nm, 32'(e), 32'({ei, ew}));
    end
  endtask

  task automatic fd_period(input bit b, output int p);
    int n = 0;
    p = -1;
    while (!(b ? fd_b : fd_a) && n < 3000) begin @(negedge clk); n++; end
    if (b ? fd_b : fd_a) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(b ? fd_b : fd_a) && n < 3000);
      if (b ? fd_b : fd_a) p = n;
    end
  endtask

  task automatic wait_idle(input bit b, input string nm);
    int n = 0;
    while ((b ? busy_b : busy_a) && n < 1000) begin @(negedge clk); n++; end
    chk(nm, 32'(b ? busy_b : busy_a), 32'd0);
  endtask

  initial begin
    int p, n, rises, cnt;
    logic prev;
    logic [15:0] b_exp [4];
    b_exp[0] = 16'h7F01; b_exp[1] = 16'h3F02; b_exp[2] = 16'h3F04; b_exp[3] = 16'h3F08;

    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_a", 32'({sclk_a, rclk_a, dio_a, idx_a, fd_a, busy_a}), 32'd0);
    chk("reset_b", 32'({sclk_b, rclk_b, dio_b, idx_b, fd_b, busy_b}), 32'd0);
    rst = 1'b0;

    // Active-high, four-digit instance
    hex_b = 16'h0008; en_b = 1'b1;
    fd_period(1'b1, p);
    chk("b_frame_period", 32'(p), 32'd284);
    for (int i = 0; i < 8; i++) check_word(1'b1, "b_word", 3'(i % 4), b_exp[i % 4]);
    en_b = 1'b0;
    wait_idle(1'b1, "b_idle");
    chk("b_blank_word", (b_q.size() != 0) ? 32'(b_q[b_q.size()-1][15:0]) : 32'hDEAD, 32'h0000);

    // Hex decode
    a_q.delete();
    mode = 1'b0; hex = 32'h0000_0001; en = 1'b1;
    check_word(1'b0, "hex_d0", 3'd0, 16'hF9FE);
    check_word(1'b0, "hex_d1", 3'd1, 16'hC0FD);
    en = 1'b0;
    wait_idle(1'b0, "hex_idle");

    // Decimal point and blanking
    a_q.delete();
    hex = 32'h0; dp = 8'h02; blank = 8'h04; en = 1'b1;
    check_word(1'b0, "dpbl_d0", 3'd0, 16'hC0FE);
    check_word(1'b0, "dpbl_d1", 3'd1, 16'h40FD);
    check_word(1'b0, "dpbl_d2", 3'd2, 16'hFFFB);
    en = 1'b0;
    wait_idle(1'b0, "dpbl_idle");

    // Raw mode; raw_in changes mid-frame and only the next frame sees it
    a_q.delete();
    dp = 8'h00; blank = 8'h00; mode = 1'b1; raw = 64'h0000_0000_5A00_0000; en = 1'b1;
    check_word(1'b0, "raw_d0", 3'd0, 16'hFFFE);
    check_word(1'b0, "raw_d1", 3'd1, 16'hFFFD);
    raw = 64'h0000_0000_1100_0000;
    check_word(1'b0, "raw_d2", 3'd2, 16'hFFFB);
    check_word(1'b0, "raw_d3_coherent", 3'd3, 16'hA5F7);
    fd_period(1'b0, p);
    chk("raw_frame_period", 32'(p), 32'd568);
    for (int k = 4; k < 8; k++) check_word(1'b0, "raw_f1_tail", 3'(k), {8'hFF, ~(8'd1 << k)});
    check_word(1'b0, "raw_f2_d0", 3'd0, 16'hFFFE);
    check_word(1'b0, "raw_f2_d1", 3'd1, 16'hFFFD);
    check_word(1'b0, "raw_f2_d2", 3'd2, 16'hFFFB);
    check_word(1'b0, "raw_f2_d3_new", 3'd3, 16'hEEF7);

    // Disable while digit 5 is shifting
    n = 0;
    while (!(idx_a == 3'd5 && sclk_a) && n < 1000) begin @(negedge clk); n++; end
    chk("dis_reach_d5_shift", 32'(idx_a == 3'd5 && sclk_a), 32'd1);
    a_q.delete();
    en = 1'b0;
    check_word(1'b0, "dis_d5", 3'd5, 16'hFFDF);
    check_word(1'b0, "dis_blank", 3'd5, 16'hFFFF);
    wait_idle(1'b0, "dis_idle");
    chk("dis_pins", 32'({sclk_a, rclk_a, dio_a}), 32'd0);

    // Reset during bit 7 of digit 2
    mode = 1'b0; hex = 32'h7654_3210; en = 1'b1;
    n = 0;
    while (idx_a != 3'd2 && n < 1000) begin @(negedge clk); n++; end
    rises = 0; prev = sclk_a; n = 0;
    while (rises < 7 && n < 500) begin
      @(negedge clk);
      if (sclk_a && !prev) rises++;
      prev = sclk_a; n++;
    end
    n = 0;
    while (sclk_a && n < 10) begin @(negedge clk); n++; end
    chk("rst_at_bit7", 32'({idx_a, sclk_a, 5'(rises)}), 32'({3'd2, 1'b0, 5'd7}));
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("rst_mid_shift", 32'({sclk_a, rclk_a, dio_a, idx_a, busy_a}), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (rclk_a) cnt++; end
    chk("no_latch_after_rst", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_hc595_scan.md
# seg7_hc595_scan

Parametrised multiplexed 7-segment display driver for the on-board 74HC595 pair (segment byte plus digit-select byte). It drives the three serial pins SCLK (seg7_SH_CP), RCLK (seg7_ST_CP) and DIO (seg7_DS), which the FPGA top level currently ties high. It scans up to 8 digits continuously, with the following features:
- per-digit hex decode or raw segment mode, decimal-point and blanking masks;
- a frame-coherent snapshot of its inputs;
- a clean blank-out when disabled.

It sits in the CLK_FPGA_SYS1 (100 MHz) domain, fed from CM33 GPIO or AHB-attached registers.

## Interface
- N_DIGITS, 8, digits scanned (1..8); digit-select bits at index N_DIGITS and above are held inactive.
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1).
- SCAN_HOLD, 1000, clk cycles each digit stays lit after latch (≥1).
- SEG_ACTIVE_LOW, 1, invert segment byte before shifting.
- DIG_ACTIVE_LOW, 1, invert digit-select byte before shifting.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- mode  in  1  0 = hex decode of hex_in; 1 = raw segments from raw_in.
- hex_in  in  4*N_DIGITS  nibble k = digit k.
- raw_in  in  8*N_DIGITS  byte k = {dp,g,f,e,d,c,b,a} for digit k.
- dp_in  in  N_DIGITS  decimal point per digit; ORed into bit 7 in both modes.
- blank_in  in  N_DIGITS  1 = digit k segment byte forced to 0x00 (active-high sense).
- seg7_sclk  out  1  595 shift clock.
- seg7_rclk  out  1  595 storage/latch clock.
- seg7_dio  out  1  serial data.
- digit_idx  out  3  digit currently shifted or lit.
- frame_done  out  1  one-cycle pulse at the end of the last digit's HOLD.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- The FSM has six states: IDLE, LOAD, SHIFT, LATCH, HOLD, BLANK.
- **IDLE**
  - If en=1, go to LOAD with digit_idx=0.
- **LOAD** (1 cycle)
  - If digit_idx=0, snapshot mode, hex_in, raw_in, dp_in and blank_in into shadow registers. A frame always uses one coherent snapshot.
  - Build the 16-bit word: bits[15:8] = segment byte, bits[7:0] = one-hot select (bit k = digit k).
  - Segment byte = LUT(nibble) or raw byte, with dp ORed into bit 7, then blanked if the blank bit is set, then inverted if SEG_ACTIVE_LOW.
  - Select byte is inverted if DIG_ACTIVE_LOW.
- **SHIFT**
  - Shift 16 bits MSB first (bit 15 first).
  - Per bit: sclk=0 for CLK_DIV cycles with dio stable, then sclk=1 for CLK_DIV cycles.
  - dio changes only on the cycle sclk goes low.
- **LATCH**
  - rclk=1 for CLK_DIV cycles; sclk=0.
- **HOLD**
  - Wait SCAN_HOLD cycles with all pins low.
  - At the end:
    - if en=0, go to BLANK;
    - else if digit_idx = N_DIGITS-1, pulse frame_done, set digit_idx=0 and go to LOAD;
    - else increment digit_idx and go to LOAD.
- **BLANK**
  - Shift and latch one word with all segments off and no digit selected (polarity applied).
  - The timing is identical to SHIFT followed by LATCH, then go to IDLE.
- en=0 during LOAD, SHIFT or LATCH does not abort; the current digit completes first.
- en reasserted during BLANK is ignored until IDLE is reached.
- N_DIGITS=1: every LOAD re-snapshots, and frame_done pulses once per digit.

## Timing
- Reset values:
  - seg7_sclk=0, seg7_rclk=0, seg7_dio=0;
  - digit_idx=0, frame_done=0, busy=0;
  - state IDLE, shadow registers 0.
- rst mid-SHIFT or mid-LATCH: all outputs take their reset values on the next edge; no partial latch is issued.
- Cycles per digit = 1 + 32·CLK_DIV + CLK_DIV + SCAN_HOLD.
- The first sclk falling edge occurs at the cycle after LOAD; sclk is 0 from LOAD onward.
- Worked example for CLK_DIV=2, SCAN_HOLD=4: 71 cycles per digit.
- frame_done is asserted on the cycle the FSM re-enters LOAD for digit 0.
- All outputs are registered, with no combinational path from the inputs.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex LUT, active-high {g..a}: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71;
  - the state enum;
  - the word width constant (16).
- Sub-module seg7_hc595_shifter:
  - loads a 16-bit word on start;
  - generates sclk/dio/rclk with CLK_DIV;
  - pulses done after LATCH.
- The scan FSM, shadow registers and word build stay in the top module.

## Test plan
All scenarios use N_DIGITS=8, CLK_DIV=2, SCAN_HOLD=4 and both ACTIVE_LOW=1 unless stated.
- **Hex digit word:** mode=0, hex_in=0x00000001, en=1 → first shifted word 0xF9FE (seg 0x06 inverted, select digit 0 inverted); rclk high 2 cycles after the 16th sclk rise.
- **DP and blank:** mode=0, dp_in=0x02, blank_in=0x04 → digit 1 word 0x40FD (0x3F|0x80 inverted); digit 2 word 0xFFFB.
- **Raw mode with frame coherence:** mode=1, raw_in byte 3 = 0x5A; change raw_in mid-frame → no effect until the next frame; digit 3 word 0xA5F7; frame_done pulses every 568 cycles.
- **Disable:** deassert en during digit 5 SHIFT → digit 5 completes, then one blank word 0xFFFF is latched, then busy=0 with all pins low.
- **Reset mid-operation:** assert rst during bit 7 of SHIFT → next edge shows sclk=rclk=dio=0 and digit_idx=0; no rclk pulse follows.
- **Polarity and digit count:** N_DIGITS=4 with SEG_ACTIVE_LOW=0 and DIG_ACTIVE_LOW=0, hex_in=0x8 → digit 0 word 0x7F01; select bits 7..4 always 0.
